// File: rtl/wb_trap_stage.sv
// Writeback stage: selects register-file/CSR write data, computes branch/jump redirects,
// prioritises exceptions/interrupts and sequences flush + redirect to the trap vector.
module wb_trap_stage #(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter bit VECTORED_EN  = 1'b1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            WB_V,
    input  logic [31:0]     WB_IR,
    input  logic [XLEN-1:0] WB_PC,
    input  logic [XLEN-1:0] WB_NPC,
    input  logic [XLEN-1:0] WB_ALU_RESULT,
    input  logic [XLEN-1:0] WB_MEM_RESULT,
    input  logic [XLEN-1:0] WB_RFD,
    input  logic [XLEN-1:0] WB_CSRFD,
    input  logic            WB_BR_TAKEN,
    input  logic [7:0]      EXC,
    input  logic [1:0]      PRIV,
    input  logic            MIE,
    input  logic            TIMER,
    input  logic            EXTERNAL,
    input  logic [XLEN-1:0] MTVEC,
    output logic [XLEN-1:0] WB_RF_DATA,
    output logic [4:0]      WB_DRID_OUT,
    output logic            WB_LD_REG,
    output logic [XLEN-1:0] WB_CSR_DATA,
    output logic            WB_ST_CSR,
    output logic            WB_PC_MUX,
    output logic [XLEN-1:0] WB_BR_JMP_TARGET,
    output logic            WB_FLUSH,
    output logic            TRAP_TAKEN,
    output logic [XLEN-1:0] WB_CAUSE,
    output logic [XLEN-1:0] WB_EPC,
    output logic            WB_BUSY
);

    // state    | meaning
    // RUN      | retiring instructions, watching for traps
    // FLUSH    | WB_FLUSH held while counter runs down
    // REDIRECT | one-cycle fetch redirect to trap vector
    typedef enum logic [1:0] {RUN, FLUSH, REDIRECT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [XLEN-1:0] tvec, tvec_nxt;

    logic [XLEN-1:0] rf_data_nxt, csr_data_nxt, target_nxt, cause_out_nxt, epc_nxt;
    logic [4:0]      drid_nxt;
    logic            ld_nxt, st_nxt, pc_mux_nxt, flush_nxt, trap_nxt, busy_nxt;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic            irq, trap;
    logic [XLEN-1:0] trap_cause, trap_target;
    logic            unused_ir;

    assign opcode    = WB_IR[6:0];
    assign funct3    = WB_IR[14:12];
    assign rd        = WB_IR[11:7];
    assign unused_ir = ^WB_IR[31:15];

    assign irq  = MIE & (EXTERNAL | TIMER);
    assign trap = irq | (|EXC);

    always_comb begin
        trap_cause = '0;
        if (irq)         trap_cause = {1'b1, (XLEN-1)'(EXTERNAL ? 11 : 7)};
        else if (EXC[1]) trap_cause = XLEN'(1);
        else if (EXC[2]) trap_cause = XLEN'(2);
        else if (EXC[0]) trap_cause = XLEN'(0);
        else if (EXC[3]) trap_cause = XLEN'(8) + XLEN'(PRIV);
        else if (EXC[6]) trap_cause = XLEN'(6);
        else if (EXC[4]) trap_cause = XLEN'(4);
        else if (EXC[7]) trap_cause = XLEN'(7);
        else if (EXC[5]) trap_cause = XLEN'(5);
    end

    // Vector offset drops the interrupt flag: 4*cause[XLEN-2:0] modulo 2^XLEN.
    always_comb begin
        trap_target = {MTVEC[XLEN-1:2], 2'b00};
        if (VECTORED_EN && MTVEC[1:0] == 2'b01 && irq)
            trap_target = trap_target + {trap_cause[XLEN-3:0], 2'b00};
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        tvec_nxt      = tvec;
        rf_data_nxt   = WB_RF_DATA;
        drid_nxt      = WB_DRID_OUT;
        csr_data_nxt  = WB_CSR_DATA;
        target_nxt    = WB_BR_JMP_TARGET;
        cause_out_nxt = WB_CAUSE;
        epc_nxt       = WB_EPC;
        ld_nxt        = 1'b0;
        st_nxt        = 1'b0;
        pc_mux_nxt    = 1'b0;
        flush_nxt     = 1'b0;
        trap_nxt      = 1'b0;
        busy_nxt      = 1'b0;
        case (state)
            RUN: begin
                if (WB_V && trap) begin
                    state_nxt     = FLUSH;
                    cnt_nxt       = CNT_INIT;
                    tvec_nxt      = trap_target;
                    cause_out_nxt = trap_cause;
                    epc_nxt       = WB_PC;
                    trap_nxt      = 1'b1;
                    flush_nxt     = 1'b1;
                    busy_nxt      = 1'b1;
                end else if (WB_V) begin
                    drid_nxt = rd;
                    case (opcode)
                        7'b0000011: begin
                            rf_data_nxt = WB_MEM_RESULT;
                            ld_nxt      = (rd != 5'd0);
                        end
                        7'b0010011, 7'b0110011, 7'b0011011,
                        7'b0111011, 7'b0110111, 7'b0010111: begin
                            rf_data_nxt = WB_ALU_RESULT;
                            ld_nxt      = (rd != 5'd0);
                        end
                        7'b1101111, 7'b1100111: begin
                            rf_data_nxt = WB_NPC;
                            ld_nxt      = (rd != 5'd0);
                            pc_mux_nxt  = 1'b1;
                            target_nxt  = WB_ALU_RESULT;
                        end
                        7'b1110011: begin
                            if (funct3 != 3'd0) begin
                                rf_data_nxt  = WB_RFD;
                                csr_data_nxt = WB_CSRFD;
                                ld_nxt       = (rd != 5'd0);
                                st_nxt       = 1'b1;
                            end
                        end
                        7'b1100011: begin
                            if (WB_BR_TAKEN) begin
                                pc_mux_nxt = 1'b1;
                                target_nxt = WB_ALU_RESULT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            FLUSH: begin
                busy_nxt = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt  = REDIRECT;
                    pc_mux_nxt = 1'b1;
                    target_nxt = tvec;
                end else begin
                    cnt_nxt   = cnt - 4'd1;
                    flush_nxt = 1'b1;
                end
            end
            REDIRECT: state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state            <= RUN;
            cnt              <= '0;
            tvec             <= '0;
            WB_RF_DATA       <= '0;
            WB_DRID_OUT      <= '0;
            WB_LD_REG        <= 1'b0;
            WB_CSR_DATA      <= '0;
            WB_ST_CSR        <= 1'b0;
            WB_PC_MUX        <= 1'b0;
            WB_BR_JMP_TARGET <= '0;
            WB_FLUSH         <= 1'b0;
            TRAP_TAKEN       <= 1'b0;
            WB_CAUSE         <= '0;
            WB_EPC           <= '0;
            WB_BUSY          <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            tvec             <= tvec_nxt;
            WB_RF_DATA       <= rf_data_nxt;
            WB_DRID_OUT      <= drid_nxt;
            WB_LD_REG        <= ld_nxt;
            WB_CSR_DATA      <= csr_data_nxt;
            WB_ST_CSR        <= st_nxt;
            WB_PC_MUX        <= pc_mux_nxt;
            WB_BR_JMP_TARGET <= target_nxt;
            WB_FLUSH         <= flush_nxt;
            TRAP_TAKEN       <= trap_nxt;
            WB_CAUSE         <= cause_out_nxt;
            WB_EPC           <= epc_nxt;
            WB_BUSY          <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_wb_trap_stage.sv
// Bench for wb_trap_stage: directed scenarios plus random traffic against a
// schedule-based reference model of retirement and trap sequencing.
module tb_wb_trap_stage;
    localparam int FC = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        wb_v, br_taken, mie, tmr, ext;
    logic [31:0] ir;
    logic [63:0] pc, npc, alu, mem, rfd, csrfd, mtvec;
    logic [7:0]  exc;
    logic [1:0]  priv;

    logic [63:0] rf_data, csr_data, target, cause, epc;
    logic [4:0]  drid;
    logic        ld, st, pc_mux, flush, trap_taken, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic ld, st, pcm, flush, trap, busy;
        logic [63:0] rf, csr, tgt, cause, epc;
        logic [4:0]  drid;
    } exp_t;

    exp_t sched[$];
    logic [63:0] m_cause = 64'd0;
    logic [63:0] m_epc = 64'd0;

    wb_trap_stage #(.XLEN(64), .FLUSH_CYCLES(FC), .VECTORED_EN(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .WB_V(wb_v), .WB_IR(ir), .WB_PC(pc), .WB_NPC(npc),
        .WB_ALU_RESULT(alu), .WB_MEM_RESULT(mem), .WB_RFD(rfd), .WB_CSRFD(csrfd),
        .WB_BR_TAKEN(br_taken), .EXC(exc), .PRIV(priv), .MIE(mie), .TIMER(tmr),
        .EXTERNAL(ext), .MTVEC(mtvec),
        .WB_RF_DATA(rf_data), .WB_DRID_OUT(drid), .WB_LD_REG(ld), .WB_CSR_DATA(csr_data),
        .WB_ST_CSR(st), .WB_PC_MUX(pc_mux), .WB_BR_JMP_TARGET(target), .WB_FLUSH(flush),
        .TRAP_TAKEN(trap_taken), .WB_CAUSE(cause), .WB_EPC(epc), .WB_BUSY(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e = '{default: '0};
        e.cause = m_cause;
        e.epc   = m_epc;
        return e;
    endfunction

    // Expected outputs one cycle after the current inputs are sampled.
    task automatic predict(output exp_t e);
        int          bits [8];
        int          codes[8];
        logic [63:0] c, t;
        logic [4:0]  rd;
        e = blank();
        if (sched.size() > 0) begin
            e = sched.pop_front();
            return;
        end
        if (!wb_v) return;
        if ((mie && (ext || tmr)) || exc != 8'd0) begin
            if (mie && (ext || tmr)) begin
                c = (64'd1 << 63) | (ext ? 64'd11 : 64'd7);
            end else begin
                bits  = '{1, 2, 0, 3, 6, 4, 7, 5};
                codes = '{1, 2, 0, 8, 6, 4, 7, 5};
                codes[3] = 8 + int'(priv);
                c = 64'd0;
                for (int i = 7; i >= 0; i--)
                    if (exc[bits[i]]) c = 64'(codes[i]);
            end
            t = mtvec & ~64'h3;
            if (mtvec[1:0] == 2'b01 && mie && (ext || tmr))
                t = t + 64'd4 * (c & ~(64'd1 << 63));
            m_cause = c;
            m_epc   = pc;
            e = blank();
            e.trap = 1'b1; e.flush = 1'b1; e.busy = 1'b1;
            for (int i = 0; i < FC - 1; i++) begin
                exp_t f;
                f = blank();
                f.flush = 1'b1; f.busy = 1'b1;
                sched.push_back(f);
            end
            begin
                exp_t r;
                r = blank();
                r.pcm = 1'b1; r.busy = 1'b1; r.tgt = t;
                sched.push_back(r);
            end
            sched.push_back(blank());
            return;
        end
        rd = ir[11:7];
        e.drid = rd;
        case (ir[6:0])
            7'h03: begin e.rf = mem; e.ld = (rd != 0); end
            7'h13, 7'h33, 7'h1B, 7'h3B, 7'h37, 7'h17: begin e.rf = alu; e.ld = (rd != 0); end
            7'h6F, 7'h67: begin e.rf = npc; e.ld = (rd != 0); e.pcm = 1'b1; e.tgt = alu; end
            7'h73: if (ir[14:12] != 3'd0) begin
                e.rf = rfd; e.csr = csrfd; e.ld = (rd != 0); e.st = 1'b1;
            end
            7'h63: if (br_taken) begin e.pcm = 1'b1; e.tgt = alu; end
            default: ;
        endcase
    endtask

    task automatic step();
        exp_t e;
        predict(e);
        @(posedge CLK);
        #1;
        check("ld_reg", 64'(ld), 64'(e.ld));
        check("st_csr", 64'(st), 64'(e.st));
        check("pc_mux", 64'(pc_mux), 64'(e.pcm));
        check("flush", 64'(flush), 64'(e.flush));
        check("trap_taken", 64'(trap_taken), 64'(e.trap));
        check("busy", 64'(busy), 64'(e.busy));
        check("cause", cause, e.cause);
        check("epc", epc, e.epc);
        if (e.ld) begin
            check("rf_data", rf_data, e.rf);
            check("drid", 64'(drid), 64'(e.drid));
        end
        if (e.st)  check("csr_data", csr_data, e.csr);
        if (e.pcm) check("target", target, e.tgt);
    endtask

    task automatic quiet();
        wb_v = 1'b0; ir = 32'h13; pc = 64'h0; npc = 64'h4; alu = 64'h0; mem = 64'h0;
        rfd = 64'h0; csrfd = 64'h0; br_taken = 1'b0; exc = 8'h0; priv = 2'd3;
        mie = 1'b0; tmr = 1'b0; ext = 1'b0; mtvec = 64'h200;
    endtask

    task automatic rand_inputs();
        logic [6:0] ops[13];
        logic [1:0] privs[3];
        ops   = '{7'h03, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h37, 7'h17,
                  7'h6F, 7'h67, 7'h73, 7'h63, 7'h23, 7'h0F};
        privs = '{2'd0, 2'd1, 2'd3};
        wb_v = ($urandom_range(0, 7) != 0);
        ir = $urandom;
        ir[6:0] = ops[$urandom_range(0, 12)];
        if ($urandom_range(0, 3) == 0) ir[11:7] = 5'd0;
        if ($urandom_range(0, 3) == 0) ir[14:12] = 3'd0;
        pc = {$urandom, $urandom}; npc = pc + 64'd4;
        alu = {$urandom, $urandom}; mem = {$urandom, $urandom};
        rfd = {$urandom, $urandom}; csrfd = {$urandom, $urandom};
        br_taken = 1'($urandom_range(0, 1));
        exc = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h0;
        priv = privs[$urandom_range(0, 2)];
        mie = 1'($urandom_range(0, 1));
        tmr = ($urandom_range(0, 11) == 0);
        ext = ($urandom_range(0, 11) == 0);
        mtvec = {$urandom, $urandom};
        mtvec[1:0] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
    endtask

    initial begin
        quiet();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ld", 64'(ld), 64'd0);
        check("reset_cause", cause, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // Load to x1
        quiet(); wb_v = 1'b1; ir = 32'h0000B083; mem = 64'hDEAD;
        step();
        check("plan_load_data", rf_data, 64'hDEAD);
        quiet(); step();
        // ADDI x0 then CSRRW x5
        quiet(); wb_v = 1'b1; ir = 32'h00000013; alu = 64'h55; step();
        quiet(); wb_v = 1'b1; ir = 32'h300012F3; rfd = 64'h11; csrfd = 64'h22; step();
        check("plan_csr_data", csr_data, 64'h22);
        // BEQ taken / not taken
        quiet(); wb_v = 1'b1; ir = 32'h00000063; alu = 64'h1000; br_taken = 1'b1; step();
        check("plan_br_target", target, 64'h1000);
        br_taken = 1'b0; step();
        // ECALL from M-mode
        quiet(); wb_v = 1'b1; ir = 32'h00000073; exc = 8'h08; pc = 64'h80; step();
        check("plan_ecall_cause", cause, 64'd11);
        quiet(); wb_v = 1'b1; ir = 32'h0000B083; mem = 64'hBAD; exc = 8'h08;
        repeat (FC) step();
        check("plan_ecall_vec", target, 64'h200);
        quiet(); step();
        // IAF and LAM together
        quiet(); wb_v = 1'b1; exc = 8'h12; pc = 64'h44; step();
        check("plan_iaf_cause", cause, 64'd1);
        quiet(); repeat (FC + 1) step();
        // Interrupts, vectored
        quiet(); wb_v = 1'b1; mie = 1'b1; tmr = 1'b1; ext = 1'b1; mtvec = 64'h201; step();
        check("plan_irq_cause", cause, 64'h8000_0000_0000_000B);
        repeat (FC) step();
        check("plan_irq_vec", target, 64'h22C);
        step();
        // Pending interrupt masked
        quiet(); wb_v = 1'b1; tmr = 1'b1; ext = 1'b1; ir = 32'h00100093; alu = 64'h7; step();
        // Pending interrupt without valid instruction
        quiet(); mie = 1'b1; tmr = 1'b1; step();

        // Reset during flush
        quiet(); wb_v = 1'b1; exc = 8'h04; pc = 64'h300; step();
        RESET = 1'b1;
        #1;
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_trap", 64'(trap_taken), 64'd0);
        check("rst_cause", cause, 64'd0);
        check("rst_epc", epc, 64'd0);
        sched.delete();
        m_cause = 64'd0;
        m_epc = 64'd0;
        @(negedge CLK);
        RESET = 1'b0;
        quiet(); wb_v = 1'b1; ir = 32'h00500113; alu = 64'h5; step();
        check("rst_addi_data", rf_data, 64'h5);

        for (int i = 0; i < 800; i++) begin
            rand_inputs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_trap_stage.md
Name: wb_trap_stage

Overview:
Parametrised writeback stage with integrated trap sequencing. Selects and registers the register-file and CSR write data per retiring instruction, and computes branch/jump redirects. Prioritises synchronous exceptions and interrupts into a cause code, and runs a flush/redirect state machine toward the trap vector. Sits between the memory stage and the register file, CSR file and fetch PC mux.

Parameters:
XLEN, 64, datapath width.
FLUSH_CYCLES, 2, cycles WB_FLUSH is held on trap entry (1..15).
VECTORED_EN, 1, when 1, honour MTVEC[1:0]==2'b01 vectored interrupt mode.

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous active-high reset
WB_V  in  1  instruction in stage is valid
WB_IR  in  32  instruction word
WB_PC  in  XLEN  PC of instruction
WB_NPC  in  XLEN  PC+4
WB_ALU_RESULT  in  XLEN  ALU result / branch target
WB_MEM_RESULT  in  XLEN  load data
WB_RFD  in  XLEN  old CSR value for rd (CSR instrs)
WB_CSRFD  in  XLEN  new CSR value
WB_BR_TAKEN  in  1  branch condition true
EXC  in  8  {SAF,SAM,LAF,LAM,ECALL,II,IAF,IAM} (bit7..0)
PRIV  in  2  current privilege (0=U,1=S,3=M)
MIE  in  1  global interrupt enable
TIMER  in  1  timer interrupt pending
EXTERNAL  in  1  external interrupt pending
MTVEC  in  XLEN  trap vector CSR
WB_RF_DATA  out  XLEN  register write data
WB_DRID_OUT  out  5  destination register
WB_LD_REG  out  1  register write enable
WB_CSR_DATA  out  XLEN  CSR write data
WB_ST_CSR  out  1  CSR write enable
WB_PC_MUX  out  1  fetch redirect
WB_BR_JMP_TARGET  out  XLEN  redirect target
WB_FLUSH  out  1  squash younger stages
TRAP_TAKEN  out  1  one-cycle trap-entry pulse
WB_CAUSE  out  XLEN  mcause value
WB_EPC  out  XLEN  mepc value
WB_BUSY  out  1  stage ignoring WB_V

Behaviour:
- All outputs registered; reset drives every output to 0 and state to RUN; RESET mid-sequence aborts the flush and clears the counter.
- Latency 1: inputs sampled in cycle N appear on the outputs in cycle N+1. Enables (LD_REG, ST_CSR, PC_MUX, TRAP_TAKEN) are single-cycle pulses, 0 when not asserted.
- Result select (RUN, WB_V=1, no trap), by opcode WB_IR[6:0]:
  - 0000011: MEM_RESULT.
  - 0010011/0110011/0011011/0111011/0110111/0010111: ALU_RESULT.
  - 1101111/1100111: NPC.
  - 1110011 with funct3!=0: RF_DATA=RFD, CSR_DATA=CSRFD, ST_CSR=1.
  - Other opcodes: no write.
- LD_REG is suppressed when rd (IR[11:7]) == 0. DRID_OUT = IR[11:7].
- Redirect: JAL/JALR, or opcode 1100011 with BR_TAKEN, gives PC_MUX=1 and target=ALU_RESULT.
- Trap detect (RUN, WB_V=1):
  - Interrupts win if MIE=1: EXTERNAL (cause 11) > TIMER (cause 7); cause MSB set.
  - Else exceptions, priority IAF(1) > II(2) > IAM(0) > ECALL(8+PRIV) > SAM(6) > LAM(4) > SAF(7) > LAF(5).
  - A trapping instruction performs no RF/CSR write and no branch redirect.
- FSM RUN -> FLUSH on trap:
  - Next cycle: TRAP_TAKEN=1, WB_CAUSE, WB_EPC=WB_PC, WB_FLUSH=1.
  - FLUSH holds WB_FLUSH for FLUSH_CYCLES cycles total (4-bit counter), then REDIRECT.
- REDIRECT (1 cycle): PC_MUX=1, WB_FLUSH=0. Target is {MTVEC[XLEN-1:2],2'b00}, plus 4*cause[XLEN-2:0] if VECTORED_EN, MTVEC[1:0]==01 and interrupt. Then RUN.
- WB_BUSY=1 in FLUSH and REDIRECT; WB_V, EXC, TIMER and EXTERNAL are ignored there.
- Interrupt pending while WB_V=0 is not taken until a valid instruction arrives.
- Cause and EPC hold until the next trap.

Test Plan:
- Load IR=0x0000B083 (rd=1), MEM_RESULT=0xDEAD -> next cycle RF_DATA=0xDEAD, DRID=1, LD_REG=1 for one cycle.
- ADDI with rd=0 -> LD_REG=0. CSRRW rd=5, RFD=0x11, CSRFD=0x22 -> LD_REG=1, ST_CSR=1, RF_DATA=0x11, CSR_DATA=0x22.
- BEQ with BR_TAKEN=1, ALU=0x1000 -> PC_MUX=1, target 0x1000. Same instruction with BR_TAKEN=0 -> PC_MUX=0.
- ECALL at PC=0x80, PRIV=3, MTVEC=0x200 -> TRAP_TAKEN pulse, CAUSE=11, EPC=0x80, FLUSH high 2 cycles, then PC_MUX=1 with target 0x200. No LD_REG. BUSY high 3 cycles.
- EXC=IAF|LAM simultaneously -> CAUSE=1. TIMER+EXTERNAL with MIE=1, MTVEC=0x201 -> CAUSE=0x8000_0000_0000_000B, target 0x22C. With MIE=0 -> no trap.
- RESET asserted during FLUSH -> all outputs 0 immediately. After release, the next valid ADDI retires normally.
